// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//   Lets two requesters share a single ALU_unit. Port 0 is the core execute
//   stage, port 1 the debug/self-test port. A round-robin arbiter grants one
//   request at a time. The granted operation is driven onto the ALU for
//   ALU_LAT+1 cycles. The ALU result is then captured and returned on a
//   valid/ready response channel, tagged with the source port and the
//   requester's tag.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   reqN_valid/ready      request handshake (N = 0,1). ready is combinational
//                         and is high only for the port granted this cycle.
//   reqN_kind             00 ALUimm, 01 ALUreg, 10 Branch, 11 illegal
//   reqN_funct3/funct7    instruction function fields
//   reqN_rs1/rs2          operands (rs2 may be a sign-extended immediate)
//   reqN_tag              opaque tag echoed on the response
//   alu_*  (out)          control and operands to ALU_unit; control is only
//                         active while an op executes
//   alu_result/correct    results from ALU_unit
//   rsp_valid/ready       response handshake; rsp_* held until taken
//   rsp_src/tag           source port and tag of the completed request
//   rsp_result/correct    captured ALU outputs (0 for an illegal kind)
//   rsp_err               1 when the request kind was illegal
//   busy                  controller is not idle
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_kind,
    input  logic [2:0]       req0_funct3,
    input  logic [6:0]       req0_funct7,
    input  logic [XLEN-1:0]  req0_rs1,
    input  logic [XLEN-1:0]  req0_rs2,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_kind,
    input  logic [2:0]       req1_funct3,
    input  logic [6:0]       req1_funct7,
    input  logic [XLEN-1:0]  req1_rs1,
    input  logic [XLEN-1:0]  req1_rs2,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             alu_isALUimm,
    output logic             alu_isALUreg,
    output logic             alu_isBranch,
    output logic [7:0]       alu_funct3oh,
    output logic [6:0]       alu_funct7,
    output logic [XLEN-1:0]  alu_rs1,
    output logic [XLEN-1:0]  alu_rs2,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_correct,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_src,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_correct,
    output logic             rsp_err,
    output logic             busy
);
    localparam int               CNT_W        = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(ALU_LAT);
    localparam logic [1:0]       KIND_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_reg;
    logic             rr_ptr_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       kind_reg;
    logic             src_reg;
    logic [TAG_W-1:0] tag_reg;

    // ---------------- arbitration ----------------
    logic [1:0] valid_vec;
    logic [1:0] grant_vec;
    logic       can_grant;
    logic       grant_any;
    logic       grant_src;

    assign valid_vec = {req1_valid, req0_valid};
    // A new op may start from IDLE, or from DONE in the very cycle the
    // pending response is taken, which gives back-to-back issue.
    assign can_grant = (state_reg == IDLE) || ((state_reg == DONE) && rsp_ready);

    // A port wins when it is valid and either the other port is idle or the
    // round-robin pointer favours it. Gating with rst_n keeps ready low while
    // reset is asserted.
    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign grant_vec[gi] = rst_n && can_grant && valid_vec[gi] &&
                               (!valid_vec[1-gi] || (rr_ptr_reg == 1'(gi)));
    end

    assign grant_any  = |grant_vec;
    assign grant_src  = grant_vec[1];
    assign req0_ready = grant_vec[0];
    assign req1_ready = grant_vec[1];

    // ---------------- granted request fields ----------------
    logic [1:0]       sel_kind;
    logic [2:0]       sel_funct3;
    logic [6:0]       sel_funct7;
    logic [XLEN-1:0]  sel_rs1;
    logic [XLEN-1:0]  sel_rs2;
    logic [TAG_W-1:0] sel_tag;
    logic [7:0]       sel_oh;

    assign sel_kind   = grant_src ? req1_kind   : req0_kind;
    assign sel_funct3 = grant_src ? req1_funct3 : req0_funct3;
    assign sel_funct7 = grant_src ? req1_funct7 : req0_funct7;
    assign sel_rs1    = grant_src ? req1_rs1    : req0_rs1;
    assign sel_rs2    = grant_src ? req1_rs2    : req0_rs2;
    assign sel_tag    = grant_src ? req1_tag    : req0_tag;

    for (genvar gi = 0; gi < 8; gi++) begin : g_oh
        assign sel_oh[gi] = (sel_funct3 == 3'(gi));
    end

    // Illegal ops never touch the ALU, so they spend a single cycle in EXEC.
    logic last_exec;
    assign last_exec = (kind_reg == KIND_ILLEGAL) || (cnt_reg == LAST_CNT);

    assign busy = (state_reg != IDLE);

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= 1'b0;
            cnt_reg      <= '0;
            kind_reg     <= '0;
            src_reg      <= 1'b0;
            tag_reg      <= '0;
            alu_isALUimm <= 1'b0;
            alu_isALUreg <= 1'b0;
            alu_isBranch <= 1'b0;
            alu_funct3oh <= '0;
            alu_funct7   <= '0;
            alu_rs1      <= '0;
            alu_rs2      <= '0;
            rsp_valid    <= 1'b0;
            rsp_src      <= 1'b0;
            rsp_tag      <= '0;
            rsp_result   <= '0;
            rsp_correct  <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if ((state_reg == DONE) && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                    if (grant_any) begin
                        state_reg  <= EXEC;
                        cnt_reg    <= '0;
                        kind_reg   <= sel_kind;
                        src_reg    <= grant_src;
                        tag_reg    <= sel_tag;
                        rr_ptr_reg <= ~grant_src;
                        // Operand outputs keep their previous value for an
                        // illegal op; only legal ops drive the ALU.
                        if (sel_kind != KIND_ILLEGAL) begin
                            alu_isALUimm <= (sel_kind == 2'b00);
                            alu_isALUreg <= (sel_kind == 2'b01);
                            alu_isBranch <= (sel_kind == 2'b10);
                            alu_funct3oh <= sel_oh;
                            alu_funct7   <= sel_funct7;
                            alu_rs1      <= sel_rs1;
                            alu_rs2      <= sel_rs2;
                        end
                    end
                end
                EXEC: begin
                    if (last_exec) begin
                        state_reg    <= DONE;
                        rsp_valid    <= 1'b1;
                        rsp_src      <= src_reg;
                        rsp_tag      <= tag_reg;
                        rsp_err      <= (kind_reg == KIND_ILLEGAL);
                        rsp_result   <= (kind_reg == KIND_ILLEGAL) ? '0 : alu_result;
                        rsp_correct  <= (kind_reg == KIND_ILLEGAL) ? 1'b0 : alu_correct;
                        alu_isALUimm <= 1'b0;
                        alu_isALUreg <= 1'b0;
                        alu_isBranch <= 1'b0;
                        alu_funct3oh <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_share_ctrl
//   Directed and randomized stimulus for alu_share_ctrl with a one-cycle
//   ALU_unit stand-in. Each cycle the outputs are compared with a
//   transaction-level reference: queued requests per port, one op in flight,
//   fixed response latency and round-robin choice between pending ports.
// -----------------------------------------------------------------------------
module tb_alu_share_ctrl;
    localparam int XLEN    = 32;
    localparam int TAG_W   = 4;
    localparam int ALU_LAT = 1;
    localparam logic [XLEN-1:0] SENTINEL = 32'hDEAD_BEEF;

    typedef struct {
        logic [1:0]       kind;
        logic [2:0]       f3;
        logic [6:0]       f7;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [TAG_W-1:0] tag;
        bit               lit;
        logic [XLEN-1:0]  lit_res;
        logic             lit_cor;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]       req0_kind, req1_kind;
    logic [2:0]       req0_funct3, req1_funct3;
    logic [6:0]       req0_funct7, req1_funct7;
    logic [XLEN-1:0]  req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic             alu_isALUimm, alu_isALUreg, alu_isBranch;
    logic [7:0]       alu_funct3oh;
    logic [6:0]       alu_funct7;
    logic [XLEN-1:0]  alu_rs1, alu_rs2, alu_result;
    logic             alu_correct;
    logic             rsp_valid, rsp_ready, rsp_src, rsp_correct, rsp_err, busy;
    logic [TAG_W-1:0] rsp_tag;
    logic [XLEN-1:0]  rsp_result;

    alu_share_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_kind(req0_kind),
        .req0_funct3(req0_funct3), .req0_funct7(req0_funct7), .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_kind(req1_kind),
        .req1_funct3(req1_funct3), .req1_funct7(req1_funct7), .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2), .req1_tag(req1_tag),
        .alu_isALUimm(alu_isALUimm), .alu_isALUreg(alu_isALUreg), .alu_isBranch(alu_isBranch),
        .alu_funct3oh(alu_funct3oh), .alu_funct7(alu_funct7), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_result(alu_result), .alu_correct(alu_correct),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_correct(rsp_correct), .rsp_err(rsp_err), .busy(busy)
    );

    // RV32 ALU behaviour: returns {correct, result}.
    function automatic logic [XLEN:0] alu_fn(input logic [1:0] kind, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        logic            c;
        logic [4:0]      sh;
        r  = '0;
        c  = 1'b0;
        sh = b[4:0];
        if (kind == 2'b10) begin
            case (f3)
                3'd0:    c = (a == b);
                3'd1:    c = (a != b);
                3'd4:    c = ($signed(a) < $signed(b));
                3'd5:    c = ($signed(a) >= $signed(b));
                3'd6:    c = (a < b);
                3'd7:    c = (a >= b);
                default: c = 1'b0;
            endcase
        end else if (kind != 2'b11) begin
            case (f3)
                3'd0: begin
                    if (kind == 2'b01 && f7[5]) r = a - b;
                    else                        r = a + b;
                end
                3'd1: r = a << sh;
                3'd2: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
                3'd3: r = {{(XLEN-1){1'b0}}, (a < b)};
                3'd4: r = a ^ b;
                3'd5: begin
                    if (f7[5]) r = $signed(a) >>> sh;
                    else       r = a >> sh;
                end
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return {c, r};
    endfunction

    // ALU_unit stand-in: decodes the controller's one-hot drive, one cycle latency.
    function automatic logic [XLEN:0] alu_unit(input logic imm, input logic regop, input logic br,
                                               input logic [7:0] oh, input logic [6:0] f7,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic [1:0] k;
        logic [2:0] f;
        if ($countones({imm, regop, br}) != 1 || !$onehot(oh)) return {1'b0, SENTINEL};
        k = imm ? 2'b00 : (regop ? 2'b01 : 2'b10);
        f = 3'd0;
        for (int i = 0; i < 8; i++) if (oh[i]) f = 3'(i);
        return alu_fn(k, f, f7, a, b);
    endfunction

    logic [XLEN:0] alu_q;
    always @(posedge clk)
        alu_q <= alu_unit(alu_isALUimm, alu_isALUreg, alu_isBranch, alu_funct3oh, alu_funct7, alu_rs1, alu_rs2);
    assign alu_result  = alu_q[XLEN-1:0];
    assign alu_correct = alu_q[XLEN];

    // ---------------- reference state ----------------
    int   nvec = 0;
    int   nerr = 0;
    req_t q0[$];
    req_t q1[$];
    bit   pres0, pres1, infl, cur_src, rr, rnd_valid, rnd_ready;
    req_t cur;
    int   acc_cyc, cyc, stall_left;
    int   grant_log[$];
    int   acc_log[$];

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic req_t mk(input logic [1:0] kind, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] lres, input logic lcor);
        req_t r;
        r.kind = kind; r.f3 = f3; r.f7 = f7; r.rs1 = a; r.rs2 = b; r.tag = tag;
        r.lit = 1'b1; r.lit_res = lres; r.lit_cor = lcor;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.kind    = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r.f3      = 3'($urandom);
        r.f7      = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        r.rs1     = $urandom;
        r.rs2     = ($urandom_range(0, 3) == 0) ? r.rs1 : $urandom;
        r.tag     = TAG_W'($urandom);
        r.lit     = 1'b0;
        r.lit_res = '0;
        r.lit_cor = 1'b0;
        return r;
    endfunction

    task automatic put(input req_t r, input bit pres, output logic v, output logic [1:0] k,
                       output logic [2:0] f3, output logic [6:0] f7, output logic [XLEN-1:0] a,
                       output logic [XLEN-1:0] b, output logic [TAG_W-1:0] t);
        v = pres; k = r.kind; f3 = r.f3; f7 = r.f7; a = r.rs1; b = r.rs2; t = r.tag;
    endtask

    // Drive inputs for the current cycle (called just after a rising edge).
    task automatic drive();
        req_t f0, f1;
        if (!pres0 && q0.size() > 0 && (!rnd_valid || $urandom_range(0, 3) != 0)) pres0 = 1'b1;
        if (!pres1 && q1.size() > 0 && (!rnd_valid || $urandom_range(0, 3) != 0)) pres1 = 1'b1;
        f0 = rnd_req();
        f1 = rnd_req();
        if (pres0) f0 = q0[0];
        if (pres1) f1 = q1[0];
        put(f0, pres0, req0_valid, req0_kind, req0_funct3, req0_funct7, req0_rs1, req0_rs2, req0_tag);
        put(f1, pres1, req1_valid, req1_kind, req1_funct3, req1_funct7, req1_rs1, req1_rs2, req1_tag);
        if (stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
        end else begin
            rsp_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    endtask

    // Check one cycle against the reference, advance it, then drive the next cycle.
    task automatic tick();
        bit            exp_rv, in_exec, can;
        int            lat, win;
        logic [XLEN:0] expv;
        @(negedge clk);
        lat     = (cur.kind == 2'b11) ? 2 : ALU_LAT + 2;
        exp_rv  = infl && (cyc >= acc_cyc + lat);
        in_exec = infl && (cyc > acc_cyc) && (cyc < acc_cyc + lat);
        chk("busy", XLEN'(busy), XLEN'(infl));
        chk("rsp_valid", XLEN'(rsp_valid), XLEN'(exp_rv));
        if (exp_rv) begin
            expv = (cur.kind == 2'b11) ? '0 : alu_fn(cur.kind, cur.f3, cur.f7, cur.rs1, cur.rs2);
            chk("rsp_src", XLEN'(rsp_src), XLEN'(cur_src));
            chk("rsp_tag", XLEN'(rsp_tag), XLEN'(cur.tag));
            chk("rsp_result", rsp_result, expv[XLEN-1:0]);
            chk("rsp_correct", XLEN'(rsp_correct), XLEN'(expv[XLEN]));
            chk("rsp_err", XLEN'(rsp_err), XLEN'(cur.kind == 2'b11));
            if (cur.lit) begin
                chk("lit_result", rsp_result, cur.lit_res);
                chk("lit_correct", XLEN'(rsp_correct), XLEN'(cur.lit_cor));
            end
        end
        if (in_exec && cur.kind != 2'b11) begin
            chk("alu_isALUimm", XLEN'(alu_isALUimm), XLEN'(cur.kind == 2'b00));
            chk("alu_isALUreg", XLEN'(alu_isALUreg), XLEN'(cur.kind == 2'b01));
            chk("alu_isBranch", XLEN'(alu_isBranch), XLEN'(cur.kind == 2'b10));
            chk("alu_funct3oh", XLEN'(alu_funct3oh), XLEN'(8'(1) << cur.f3));
            chk("alu_funct7", XLEN'(alu_funct7), XLEN'(cur.f7));
            chk("alu_rs1", alu_rs1, cur.rs1);
            chk("alu_rs2", alu_rs2, cur.rs2);
        end else begin
            chk("alu_is_off", XLEN'({alu_isALUimm, alu_isALUreg, alu_isBranch}), '0);
            chk("alu_oh_off", XLEN'(alu_funct3oh), '0);
        end
        can = !infl || (exp_rv && rsp_ready);
        win = -1;
        if (can) begin
            if (pres0 && (!pres1 || !rr)) win = 0;
            else if (pres1)               win = 1;
        end
        chk("req0_ready", XLEN'(req0_ready), XLEN'(win == 0));
        chk("req1_ready", XLEN'(req1_ready), XLEN'(win == 1));
        if (exp_rv && rsp_ready) infl = 1'b0;
        if (win == 0) begin
            cur = q0.pop_front();
            pres0 = 1'b0;
        end else if (win == 1) begin
            cur = q1.pop_front();
            pres1 = 1'b0;
        end
        if (win >= 0) begin
            cur_src = (win == 1);
            acc_cyc = cyc;
            infl    = 1'b1;
            rr      = (win == 0);
            grant_log.push_back(win);
            acc_log.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || infl || pres0 || pres1) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", XLEN'(n < budget), XLEN'(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pres0 = 1'b0;
        pres1 = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_busy", XLEN'(busy), '0);
        chk("rst_readys", XLEN'({req0_ready, req1_ready}), '0);
        chk("rst_alu_ctl", XLEN'({alu_isALUimm, alu_isALUreg, alu_isBranch, alu_funct3oh, alu_funct7}), '0);
        chk("rst_alu_rs1", alu_rs1, '0);
        chk("rst_alu_rs2", alu_rs2, '0);
        chk("rst_rsp_ctl", XLEN'({rsp_valid, rsp_src, rsp_tag, rsp_correct, rsp_err}), '0);
        chk("rst_rsp_result", rsp_result, '0);
        rst_n = 1'b1;
        infl  = 1'b0;
        rr    = 1'b0;
        q0.delete();
        q1.delete();
        drive();
    endtask

    initial begin
        int m;
        int n;
        rst_n = 1'b0; rsp_ready = 1'b0;
        pres0 = 1'b0; pres1 = 1'b0; infl = 1'b0; rr = 1'b0; cur_src = 1'b0;
        rnd_valid = 1'b0; rnd_ready = 1'b0; stall_left = 0; acc_cyc = 0; cyc = 0;
        cur = rnd_req();
        req0_valid = 1'b0; req1_valid = 1'b0;
        do_reset();

        // ADD on port 0
        q0.push_back(mk(2'b01, 3'd0, 7'b0000000, 32'd7, 32'd8, 4'h1, 32'd15, 1'b0));
        drive();
        run_until_idle(50);

        // SUB and SRA on port 1
        q1.push_back(mk(2'b01, 3'd0, 7'b0100000, 32'd8, 32'd5, 4'h2, 32'd3, 1'b0));
        q1.push_back(mk(2'b01, 3'd5, 7'b0100000, 32'hF000_0000, 32'd12, 4'h3, 32'hFFFF_0000, 1'b0));
        drive();
        run_until_idle(50);

        // Branches BLT (taken) and BLTU (not taken) on port 0
        q0.push_back(mk(2'b10, 3'd4, 7'b0, 32'hFFFF_FFF3, 32'h7FFF_FFF4, 4'h4, 32'd0, 1'b1));
        q0.push_back(mk(2'b10, 3'd6, 7'b0, 32'hFFFF_FFF3, 32'h7FFF_FFF4, 4'h5, 32'd0, 1'b0));
        drive();
        run_until_idle(50);

        // Illegal kind on both ports
        q0.push_back(mk(2'b11, 3'd0, 7'b0, 32'd1, 32'd2, 4'h6, 32'd0, 1'b0));
        q1.push_back(mk(2'b11, 3'd7, 7'b0100000, 32'd3, 32'd4, 4'h7, 32'd0, 1'b0));
        drive();
        run_until_idle(50);

        // Response back-pressure: held 5 cycles, other port granted on release
        q0.push_back(mk(2'b00, 3'd4, 7'b0, 32'h0F0F_0F0F, 32'h00FF_00FF, 4'h8, 32'h0FF0_0FF0, 1'b0));
        q1.push_back(mk(2'b00, 3'd6, 7'b0, 32'h1000_0000, 32'h0000_0001, 4'h9, 32'h1000_0001, 1'b0));
        stall_left = 8;
        drive();
        m = acc_log.size();
        run_until_idle(50);
        chk("stall_regrant_gap", XLEN'(acc_log[m+1] - acc_log[m]), XLEN'(8));

        // Fairness and issue interval with both ports continuously valid
        do_reset();
        m = grant_log.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(2'b01, 3'd0, 7'b0, 32'(i), 32'(100), TAG_W'(i), 32'(i + 100), 1'b0));
            q1.push_back(mk(2'b00, 3'd0, 7'b0, 32'(i), 32'(200), TAG_W'(i + 8), 32'(i + 200), 1'b0));
        end
        drive();
        run_until_idle(100);
        for (int i = 0; i < 8; i++)
            chk("grant_order", XLEN'(grant_log[m+i]), XLEN'(i % 2));
        for (int i = 0; i < 7; i++)
            chk("issue_interval", XLEN'(acc_log[m+i+1] - acc_log[m+i]), XLEN'(ALU_LAT + 2));

        // Reset while an op from port 0 is executing
        q0.push_back(mk(2'b01, 3'd7, 7'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'hA, 32'h0F0F_0000, 1'b0));
        drive();
        n = 0;
        while (!(infl && cyc == acc_cyc + 1) && n < 20) begin
            tick();
            n++;
        end
        chk("reach_exec", XLEN'(n < 20), XLEN'(1));
        do_reset();
        m = grant_log.size();
        q0.push_back(mk(2'b00, 3'd0, 7'b0, 32'd1, 32'd1, 4'hB, 32'd2, 1'b0));
        q1.push_back(mk(2'b00, 3'd0, 7'b0, 32'd2, 32'd2, 4'hC, 32'd4, 1'b0));
        drive();
        run_until_idle(50);
        chk("post_reset_grant", XLEN'((grant_log.size() > m) ? grant_log[m] : -1), XLEN'(0));

        // Randomized traffic with random arrival and response back-pressure
        rnd_valid = 1'b1;
        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) q1.push_back(rnd_req());
            else                           q0.push_back(rnd_req());
        end
        drive();
        run_until_idle(3000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
